forwarding_hazard_scoreboard: RTL and testbench

Parametrised successor of the ID/EXE forwarding logic for the RV32IM pipeline. It generates operand-forwarding selects from any number of downstream stages with nearest-stage priority and never forwards from x0. It also adds the sequential hazard handling that pure forwarding cannot cover: a one-cycle load-use stall and a scoreboard for one outstanding multi-cycle M-extension operation (MUL/DIV). It sits beside the ID stage and drives the operand muxes and the pipeline STALL line.

---
 rtl/forwarding_hazard_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_forwarding_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_scoreboard.sv
// Purpose : ID-stage operand forwarding selects plus load-use / MUL-DIV hazard stall control.
// Latency : DATAxSEL and STALL are combinational (zero latency); scoreboard/counter update on CLK.
// Backpr. : STALL holds PC/IF/ID and bubbles EXE; one outstanding MUL/DIV op, extra issues flag LONG_ERR.
module forwarding_hazard_scoreboard #(
    parameter int AW         = 5,
    parameter int NUM_STAGES = 3,
    parameter int SELW       = 2,
    parameter int CNTW       = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [AW-1:0]            ID_ADDR1,
    input  logic [AW-1:0]            ID_ADDR2,
    input  logic                     ID_RS1_USED,
    input  logic                     ID_RS2_USED,
    input  logic [NUM_STAGES*AW-1:0] STG_ADDR,
    input  logic [NUM_STAGES-1:0]    STG_WREN,
    input  logic                     EXE_IS_LOAD,
    input  logic                     LONG_ISSUE,
    input  logic [AW-1:0]            LONG_ADDR,
    input  logic                     LONG_DONE,
    output logic [SELW-1:0]          DATA1SEL,
    output logic [SELW-1:0]          DATA2SEL,
    output logic                     STALL,
    output logic                     LONG_BUSY,
    output logic [AW-1:0]            LONG_PEND_ADDR,
    output logic                     LONG_ERR,
    output logic [CNTW-1:0]          STALL_CNT
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_LWAIT   = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            stall_int;

    logic            busy;
    logic            busy_nxt;
    logic [AW-1:0]   pend_addr;
    logic [AW-1:0]   pend_addr_nxt;
    logic            err;
    logic            err_nxt;
    logic [CNTW-1:0] stall_cnt;

    logic            src1_ok;
    logic            src2_ok;
    logic [SELW-1:0] sel1_raw;
    logic [SELW-1:0] sel2_raw;
    logic            hit1_s0;
    logic            hit2_s0;
    logic            load_haz;
    logic            long_haz;

    // x0 is hardwired zero and unused sources never need a value, so neither can match
    assign src1_ok = ID_RS1_USED && (ID_ADDR1 != '0);
    assign src2_ok = ID_RS2_USED && (ID_ADDR2 != '0);

    // Nearest-stage priority: scan far to near so the lowest matching index wins
    always_comb begin
        sel1_raw = '0;
        sel2_raw = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (src1_ok && STG_WREN[i] && (STG_ADDR[i*AW +: AW] == ID_ADDR1)) begin
                sel1_raw = SELW'(i + 1);
            end
            if (src2_ok && STG_WREN[i] && (STG_ADDR[i*AW +: AW] == ID_ADDR2)) begin
                sel2_raw = SELW'(i + 1);
            end
        end
    end

    assign hit1_s0  = src1_ok && STG_WREN[0] && (STG_ADDR[AW-1:0] == ID_ADDR1);
    assign hit2_s0  = src2_ok && STG_WREN[0] && (STG_ADDR[AW-1:0] == ID_ADDR2);

    // A load in EXE has no data yet; a consumer right behind it must wait one cycle
    assign load_haz = EXE_IS_LOAD && (hit1_s0 || hit2_s0);

    // Outstanding MUL/DIV result is not in any forwarding stage until LONG_DONE
    assign long_haz = busy && ((src1_ok && (ID_ADDR1 == pend_addr)) ||
                               (src2_ok && (ID_ADDR2 == pend_addr)));

    // Hazard FSM: stall decode and next-state selection
    always_comb begin
        state_nxt = state;
        stall_int = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_int = load_haz || long_haz;
                if (load_haz) begin
                    state_nxt = ST_LDSTALL;
                end else if (long_haz && !LONG_DONE) begin
                    // If the result lands this very cycle, MEM forwarding covers it next cycle
                    state_nxt = ST_LWAIT;
                end
            end
            ST_LDSTALL: begin
                // The bubble sits in EXE and the load is in MEM now; only a long op can still block
                stall_int = long_haz;
                state_nxt = ST_IDLE;
            end
            ST_LWAIT: begin
                stall_int = 1'b1;
                if (LONG_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scoreboard next state: a done retires the old op before a same-cycle issue claims the slot
    always_comb begin
        busy_nxt      = busy;
        pend_addr_nxt = pend_addr;
        err_nxt       = err;
        if (LONG_DONE && busy) begin
            busy_nxt      = 1'b0;
            pend_addr_nxt = '0;
        end
        if (LONG_ISSUE && (LONG_ADDR != '0)) begin
            if (!busy || LONG_DONE) begin
                busy_nxt      = 1'b1;
                pend_addr_nxt = LONG_ADDR;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // Scoreboard registers; the error flag is sticky until reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy      <= 1'b0;
            pend_addr <= '0;
            err       <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            pend_addr <= pend_addr_nxt;
            err       <= err_nxt;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

    // While waiting on MUL/DIV the operands are refetched after the stall, so muxes park on the RF
    assign DATA1SEL       = (state == ST_LWAIT) ? '0 : sel1_raw;
    assign DATA2SEL       = (state == ST_LWAIT) ? '0 : sel2_raw;
    assign STALL          = RESET && stall_int;
    assign LONG_BUSY      = busy;
    assign LONG_PEND_ADDR = pend_addr;
    assign LONG_ERR       = err;
    assign STALL_CNT      = stall_cnt;

endmodule

// File: tb/tb_forwarding_hazard_scoreboard.sv
// Purpose : table-driven check of forwarding selects, load-use and MUL/DIV hazard handling.
// Latency : inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpr. : none; a watchdog bounds the run.
module tb_forwarding_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_ADDR1, ID_ADDR2;
    logic        ID_RS1_USED, ID_RS2_USED;
    logic [14:0] STG_ADDR;
    logic [2:0]  STG_WREN;
    logic        EXE_IS_LOAD, LONG_ISSUE, LONG_DONE;
    logic [4:0]  LONG_ADDR;

    logic [1:0]  DATA1SEL, DATA2SEL;
    logic        STALL, LONG_BUSY, LONG_ERR;
    logic [4:0]  LONG_PEND_ADDR;
    logic [15:0] STALL_CNT;

    logic [1:0]  s_DATA1SEL, s_DATA2SEL;
    logic        s_STALL, s_LONG_BUSY, s_LONG_ERR;
    logic [4:0]  s_LONG_PEND_ADDR;
    logic [3:0]  s_STALL_CNT;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    forwarding_hazard_scoreboard dut (
        .CLK(CLK), .RESET(RESET),
        .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .STG_ADDR(STG_ADDR), .STG_WREN(STG_WREN), .EXE_IS_LOAD(EXE_IS_LOAD),
        .LONG_ISSUE(LONG_ISSUE), .LONG_ADDR(LONG_ADDR), .LONG_DONE(LONG_DONE),
        .DATA1SEL(DATA1SEL), .DATA2SEL(DATA2SEL), .STALL(STALL),
        .LONG_BUSY(LONG_BUSY), .LONG_PEND_ADDR(LONG_PEND_ADDR),
        .LONG_ERR(LONG_ERR), .STALL_CNT(STALL_CNT)
    );

    forwarding_hazard_scoreboard #(.CNTW(4)) dut_sat (
        .CLK(CLK), .RESET(RESET),
        .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .STG_ADDR(STG_ADDR), .STG_WREN(STG_WREN), .EXE_IS_LOAD(EXE_IS_LOAD),
        .LONG_ISSUE(LONG_ISSUE), .LONG_ADDR(LONG_ADDR), .LONG_DONE(LONG_DONE),
        .DATA1SEL(s_DATA1SEL), .DATA2SEL(s_DATA2SEL), .STALL(s_STALL),
        .LONG_BUSY(s_LONG_BUSY), .LONG_PEND_ADDR(s_LONG_PEND_ADDR),
        .LONG_ERR(s_LONG_ERR), .STALL_CNT(s_STALL_CNT)
    );

    typedef struct {
        string      name;
        logic [4:0] a1;
        logic       u1;
        logic [4:0] a2;
        logic       u2;
        logic [4:0] s0, s1, s2;
        logic [2:0] wren;
        logic       ld;
        logic       iss;
        logic [4:0] la;
        logic       dn;
        logic [1:0] e1, e2;
        logic       est, ebusy;
        logic [4:0] epend;
        logic       eerr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input string nm,
        input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] wren,
        input logic ld, input logic iss, input logic [4:0] la, input logic dn,
        input logic [1:0] e1, input logic [1:0] e2, input logic est, input logic ebusy,
        input logic [4:0] epend, input logic eerr, input logic [15:0] ecnt);
        vec_t v;
        v.name = nm; v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.wren = wren;
        v.ld = ld; v.iss = iss; v.la = la; v.dn = dn;
        v.e1 = e1; v.e2 = e2; v.est = est; v.ebusy = ebusy;
        v.epend = epend; v.eerr = eerr; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_ADDR1    = v.a1;
        ID_RS1_USED = v.u1;
        ID_ADDR2    = v.a2;
        ID_RS2_USED = v.u2;
        STG_ADDR    = {v.s2, v.s1, v.s0};
        STG_WREN    = v.wren;
        EXE_IS_LOAD = v.ld;
        LONG_ISSUE  = v.iss;
        LONG_ADDR   = v.la;
        LONG_DONE   = v.dn;
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk(e.name, "DATA1SEL",       32'(DATA1SEL),       32'(e.e1));
            chk(e.name, "DATA2SEL",       32'(DATA2SEL),       32'(e.e2));
            chk(e.name, "STALL",          32'(STALL),          32'(e.est));
            chk(e.name, "LONG_BUSY",      32'(LONG_BUSY),      32'(e.ebusy));
            chk(e.name, "LONG_PEND_ADDR", 32'(LONG_PEND_ADDR), 32'(e.epend));
            chk(e.name, "LONG_ERR",       32'(LONG_ERR),       32'(e.eerr));
            chk(e.name, "STALL_CNT",      32'(STALL_CNT),      32'(e.ecnt));
        end
    endtask

    // Drive a vector, sample at the falling edge, then advance past the next rising edge
    task automatic step(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(negedge CLK);
        check_out();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Reset: load hazard on the inputs must not stall; forwarding stays live
        RESET = 1'b0;
        v = mk("reset", 0,1,7,1, 7,0,0,3'b001, 1,0,0,0, 0,1,0,0,0,0,0);
        drive(v);
        exp_q.push_back(v);
        #2;
        check_out();
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        //            name           a1 u1 a2 u2  s0 s1 s2 wren    ld is la dn  e1 e2 st bz pd er cnt
        tbl.push_back(mk("prio_all",   5,1, 0,1,  5, 5, 5,3'b111, 0,0, 0,0, 1,0,0,0, 0,0,0));
        tbl.push_back(mk("prio_mem",   5,1, 0,1,  5, 5, 5,3'b110, 0,0, 0,0, 2,0,0,0, 0,0,0));
        tbl.push_back(mk("prio_wb",    5,1, 0,1,  5, 5, 5,3'b100, 0,0, 0,0, 3,0,0,0, 0,0,0));
        tbl.push_back(mk("prio_none",  5,1, 0,1,  5, 5, 5,3'b000, 0,0, 0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk("x0_src",     0,1, 0,1,  0, 0, 0,3'b111, 1,0, 0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk("rs2_unused", 0,1, 6,0,  6, 6, 6,3'b111, 0,0, 0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk("rs1_unused", 6,0, 6,1,  6, 6, 6,3'b110, 0,0, 0,0, 0,2,0,0, 0,0,0));
        tbl.push_back(mk("wren0_low",  0,1, 7,1,  7, 0, 0,3'b000, 1,0, 0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk("mixed",      4,1, 8,1,  1, 8, 4,3'b111, 0,0, 0,0, 3,2,0,0, 0,0,0));
        // load-use: one stall cycle, then forward from MEM
        tbl.push_back(mk("ld_use",     0,1, 7,1,  7, 0, 0,3'b001, 1,0, 0,0, 0,1,1,0, 0,0,0));
        tbl.push_back(mk("ld_fwd",     0,1, 7,1,  0, 7, 0,3'b010, 0,0, 0,0, 0,2,0,0, 0,0,1));
        tbl.push_back(mk("ld_after",   0,1, 7,1,  0, 7, 0,3'b010, 0,0, 0,0, 0,2,0,0, 0,0,1));
        // long op on rd=9
        tbl.push_back(mk("long_iss",   0,1, 0,1,  0, 0, 0,3'b000, 0,1, 9,0, 0,0,0,0, 0,0,1));
        tbl.push_back(mk("long_other",10,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,0, 0,0,0,1, 9,0,1));
        tbl.push_back(mk("long_dep",   9,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,0, 0,0,1,1, 9,0,1));
        tbl.push_back(mk("lwait_force",9,1, 0,1,  0, 0, 9,3'b100, 0,0, 0,0, 0,0,1,1, 9,0,2));
        tbl.push_back(mk("lwait",      9,1, 0,1,  0, 0, 9,3'b100, 0,0, 0,0, 0,0,1,1, 9,0,3));
        tbl.push_back(mk("lwait_done", 9,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,1, 0,0,1,1, 9,0,4));
        tbl.push_back(mk("long_fwd",   9,1, 0,1,  0, 9, 0,3'b010, 0,0, 0,0, 2,0,0,0, 0,0,5));
        // scoreboard corner cases
        tbl.push_back(mk("iss12",      0,1, 0,1,  0, 0, 0,3'b000, 0,1,12,0, 0,0,0,0, 0,0,5));
        tbl.push_back(mk("iss3_done",  0,1, 0,1,  0, 0, 0,3'b000, 0,1, 3,1, 0,0,0,1,12,0,5));
        tbl.push_back(mk("iss_busy",   0,1, 0,1,  0, 0, 0,3'b000, 0,1,14,0, 0,0,0,1, 3,0,5));
        tbl.push_back(mk("err_set",    0,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,0, 0,0,0,1, 3,1,5));
        tbl.push_back(mk("done",       0,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,1, 0,0,0,1, 3,1,5));
        tbl.push_back(mk("iss_x0",     0,1, 0,1,  0, 0, 0,3'b000, 0,1, 0,0, 0,0,0,0, 0,1,5));
        tbl.push_back(mk("done_idle",  0,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,1, 0,0,0,0, 0,1,5));
        tbl.push_back(mk("idle",       0,1, 0,1,  0, 0, 0,3'b000, 0,0, 0,0, 0,0,0,0, 0,1,5));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Asynchronous reset while waiting on a long op
        step(mk("r_iss",  0,1,0,1, 0,0,0,3'b000, 0,1,20,0, 0,0,0,0, 0,1,5));
        step(mk("r_dep", 20,1,0,1, 0,0,0,3'b000, 0,0, 0,0, 0,0,1,1,20,1,5));
        v = mk("r_lwait", 20,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,1,1,20,1,6);
        drive(v);
        exp_q.push_back(v);
        @(negedge CLK);
        check_out();
        #2;
        RESET = 1'b0;
        #1;
        exp_q.push_back(mk("r_async", 20,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,0,0,0,0,0));
        check_out();
        @(posedge CLK);
        #1;
        step(mk("r_held", 20,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,0,0,0,0,0));
        RESET = 1'b1;
        step(mk("r_post", 20,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,0,0,0,0,0));

        // Saturation: hold STALL for 20 cycles via an unfinished long op
        step(mk("sat_iss", 0,1,0,1, 0,0,0,3'b000, 0,1,21,0, 0,0,0,0,0,0,0));
        for (int k = 0; k < 20; k++) begin
            step(mk("sat_hold", 21,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,1,1,21,0,16'(k)));
        end
        chk("sat", "STALL_CNT_w4", 32'(s_STALL_CNT), 32'd15);
        step(mk("sat_done", 21,1,0,1, 0,0,0,3'b000, 0,0,0,1, 0,0,1,1,21,0,20));
        step(mk("sat_idle", 21,1,0,1, 0,0,0,3'b000, 0,0,0,0, 0,0,0,0, 0,0,21));
        chk("sat_end", "STALL_CNT_w4", 32'(s_STALL_CNT), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
